// File: rtl/led_blink_scheduler.sv
// Purpose: shares one status LED between NREQ requesters, playing the winner's blink-count code as
//          N ON/OFF blinks followed by an inter-frame gap, then re-arbitrating.
// Latency: grant is combinational in the single IDLE cycle; the frame starts (busy=1, led=1) on the next cycle.
// Backpressure: none; requests are levels that simply wait while a frame plays (non-preemptive).
//
// Ports:
//   clk        system clock (2 MHz nominal)
//   rstb       async active-low reset
//   ena        scheduler enable; low forces IDLE with the LED off, without a done pulse
//   req        level request per requester
//   code       per-requester blink count, slice i = code[i*CW +: CW]; zero means "not eligible"
//   led        LED drive, high only while a blink is on
//   grant      one-hot, 1-cycle pulse in the cycle a frame is accepted
//   done       1-cycle pulse on the last cycle of the inter-frame gap
//   busy       high while a frame is in progress
//   active_id  index of the requester whose frame is playing; held after the frame ends
//
// Optional feature: define LED_SCHED_RR_EN for round-robin arbitration; default is fixed priority
// (lowest eligible index wins).
module led_blink_scheduler #(
  parameter int NREQ    = 4,
  parameter int CW      = 4,
  parameter int IDW     = 2,
  parameter int CLK_DIV = 2000,
  parameter int ON_MS   = 150,
  parameter int OFF_MS  = 250,
  parameter int GAP_MS  = 1000
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 ena,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CW-1:0]   code,
  output logic                 led,
  output logic [NREQ-1:0]      grant,
  output logic                 done,
  output logic                 busy,
  output logic [IDW-1:0]       active_id
);

  localparam int MAX_OF2 = (ON_MS > OFF_MS) ? ON_MS : OFF_MS;
  localparam int MAX_MS  = (MAX_OF2 > GAP_MS) ? MAX_OF2 : GAP_MS;
  localparam int MSW     = (MAX_MS > 1) ? $clog2(MAX_MS) : 1;
  localparam int DVW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

  state_t           state, state_nxt;
  logic [DVW-1:0]   div;
  logic [MSW-1:0]   msc;
  logic [MSW-1:0]   dur_end;
  logic [CW-1:0]    rem;
  logic             tick;
  logic             expire;
  logic             start;
  logic [NREQ-1:0]  elig;
  logic             win_vld;
  logic [IDW-1:0]   win_idx;
  logic [CW-1:0]    win_code;

  // Eligibility: a requester with a zero code is never considered.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req[i] && (code[i*CW +: CW] != '0);
    end
  end

`ifdef LED_SCHED_RR_EN
  logic [IDW-1:0] ptr;

  // Scan from ptr upwards (modulo NREQ); walking downwards lets the closest index overwrite.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (elig[idx]) begin
        win_vld = 1'b1;
        win_idx = IDW'(idx);
      end
    end
  end

  // Pointer moves only on a completed frame, so an ena abort leaves it untouched.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ptr <= '0;
    end else if (done) begin
      ptr <= IDW'((int'(active_id) + 1) % NREQ);
    end
  end
`else
  // Fixed priority: walking downwards leaves the lowest eligible index as the winner.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (elig[k]) begin
        win_vld = 1'b1;
        win_idx = IDW'(k);
      end
    end
  end
`endif

  always_comb begin
    win_code = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == win_idx) win_code = code[i*CW +: CW];
    end
  end

  // A state of D ms ends on the tick where msc == D-1, giving exactly D*CLK_DIV cycles.
  assign tick = (div == DVW'(CLK_DIV-1));

  always_comb begin
    dur_end = '0;
    case (state)
      S_ON:    dur_end = MSW'(ON_MS-1);
      S_OFF:   dur_end = MSW'(OFF_MS-1);
      S_GAP:   dur_end = MSW'(GAP_MS-1);
      default: dur_end = '0;
    endcase
  end

  assign expire = tick && (msc == dur_end);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    led       = 1'b0;
    busy      = 1'b0;
    grant     = '0;
    done      = 1'b0;
    start     = 1'b0;
    case (state)
      S_IDLE: begin
        if (win_vld) begin
          start          = 1'b1;
          grant[win_idx] = 1'b1;
          state_nxt      = S_ON;
        end
      end
      S_ON: begin
        led  = 1'b1;
        busy = 1'b1;
        if (expire) state_nxt = S_OFF;
      end
      S_OFF: begin
        busy = 1'b1;
        // rem was already decremented when ON was left.
        if (expire) state_nxt = (rem != '0) ? S_ON : S_GAP;
      end
      S_GAP: begin
        busy = 1'b1;
        if (expire) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Disable overrides everything: abort to IDLE, no grant, no done.
    if (!ena) begin
      state_nxt = S_IDLE;
      grant     = '0;
      done      = 1'b0;
      start     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      div       <= '0;
      msc       <= '0;
      rem       <= '0;
      active_id <= '0;
    end else begin
      // Timing base restarts on every state entry and stays cleared in IDLE.
      if ((state_nxt != state) || (state_nxt == S_IDLE)) begin
        div <= '0;
        msc <= '0;
      end else if (tick) begin
        div <= '0;
        msc <= msc + 1'b1;
      end else begin
        div <= div + 1'b1;
      end

      if (!ena) begin
        rem <= '0;
      end else if (start) begin
        rem <= win_code;
      end else if ((state == S_ON) && expire) begin
        rem <= rem - 1'b1;
      end

      if (start) active_id <= win_idx;
    end
  end

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Scoreboard bench: stimulus pushes the expected frames (winner, code, abort point, grant cycle)
// into a queue; a negedge monitor pops them on grant and checks every output cycle by cycle
// against the blink waveform derived from the code.
module tb_led_blink_scheduler;
  localparam int NREQ    = 4;
  localparam int CW      = 4;
  localparam int IDW     = 2;
  localparam int CLK_DIV = 4;
  localparam int ON_MS   = 2;
  localparam int OFF_MS  = 2;
  localparam int GAP_MS  = 3;
  localparam int ONC     = ON_MS * CLK_DIV;
  localparam int OFFC    = OFF_MS * CLK_DIV;
  localparam int GAPC    = GAP_MS * CLK_DIV;
  localparam int BLK     = ONC + OFFC;
  localparam int CDW     = NREQ * CW;
  localparam int VW      = 3 + NREQ + IDW;

  logic            clk  = 1'b0;
  logic            rstb = 1'b0;
  logic            ena  = 1'b0;
  logic [NREQ-1:0] req  = '0;
  logic [CDW-1:0]  code = '0;
  logic            led, done, busy;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  active_id;

  led_blink_scheduler #(
    .NREQ(NREQ), .CW(CW), .IDW(IDW), .CLK_DIV(CLK_DIV),
    .ON_MS(ON_MS), .OFF_MS(OFF_MS), .GAP_MS(GAP_MS)
  ) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .req(req), .code(code),
    .led(led), .grant(grant), .done(done), .busy(busy), .active_id(active_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    int id;
    int code;
    int abort_t;   // frame cycle where ena is low, -1 if the frame completes
    int at;        // absolute grant cycle, -1 means right after the previous done
  } item_t;

  item_t expq[$];
  int    m_ptr = 0;

  // Frame cycle t: 0 = grant cycle, blinks occupy 1..code*BLK, then the gap.
  function automatic logic exp_led(int t, int c);
    return (t >= 1) && (t <= c*BLK) && (((t-1) % BLK) < ONC);
  endfunction

  function automatic int frame_end(int c);
    return c*BLK + GAPC;
  endfunction

  function automatic logic [NREQ-1:0] onehot(int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int slice(logic [CDW-1:0] cd, int i);
    return int'(cd[i*CW +: CW]);
  endfunction

  function automatic int arb(logic [NREQ-1:0] m, logic [CDW-1:0] cd);
    int p;
`ifdef LED_SCHED_RR_EN
    p = m_ptr;
`else
    p = 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (p + k) % NREQ;
      if (m[i] && slice(cd, i) != 0) return i;
    end
    return -1;
  endfunction

  task automatic chk(string name, logic [VW-1:0] act, logic [VW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cyc=%0d led/busy/done/grant/id got=%b required=%b", name, cyc, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  item_t cur;
  int    t_f      = 0;
  bit    in_frame = 1'b0;
  int    last_end = -10;
  int    last_id  = 0;

  always @(negedge clk) begin
    logic [VW-1:0]   act;
    logic [VW-1:0]   ex;
    logic [NREQ-1:0] eg;
    bit              due;
    act = {led, busy, done, grant, active_id};
    if (!rstb) begin
      in_frame = 1'b0;
      last_id  = 0;
      last_end = -10;
      expq.delete();
      chk("reset", act, '0);
    end else if (in_frame) begin
      t_f++;
      ex = {exp_led(t_f, cur.code), 1'b1,
            (t_f == frame_end(cur.code)) && (t_f != cur.abort_t),
            {NREQ{1'b0}}, IDW'(cur.id)};
      chk("frame", act, ex);
      if (t_f == cur.abort_t) begin
        in_frame = 1'b0;
        last_end = -10;
      end else if (t_f == frame_end(cur.code)) begin
        in_frame = 1'b0;
        last_end = cyc;
      end
    end else begin
      due = 1'b0;
      eg  = '0;
      if (expq.size() > 0) begin
        due = (expq[0].at >= 0) ? (cyc == expq[0].at) : (cyc == last_end + 1);
        if (due) eg = onehot(expq[0].id);
      end
      ex = {3'b000, eg, IDW'(last_id)};
      chk("idle", act, ex);
      if (due) begin
        cur = expq.pop_front();
        if (grant == onehot(cur.id)) begin
          in_frame = 1'b1;
          t_f      = 0;
          last_id  = cur.id;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(int id, int c, int abort_t, int at);
    item_t it;
    it.id      = id;
    it.code    = c;
    it.abort_t = abort_t;
    it.at      = at;
    expq.push_back(it);
    if (abort_t < 0) m_ptr = (id + 1) % NREQ;
  endtask

  task automatic wait_grant(output bit got);
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (grant != '0) begin
        got = 1'b1;
        break;
      end
    end
    compared++;
    if (!got) begin
      mismatched++;
      $display("FAIL grant_timeout cyc=%0d got no grant, required one within 40 cycles", cyc);
    end
  endtask

  // Called right after the grant cycle; walks frame cycles 1..stop_t.
  task automatic play(int stop_t, int drop_t, logic [NREQ-1:0] drop_m,
                      logic [CDW-1:0] new_code, int abort_t);
    for (int t = 1; t <= stop_t; t++) begin
      step();
      if (t == drop_t) begin
        req  = req & ~drop_m;
        code = new_code;
      end
      if (t == abort_t) ena = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got no completion, required finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit             got;
    int             w, e, ab;
    logic [NREQ-1:0] m;
    logic [CDW-1:0]  cd, rc;

    repeat (3) @(posedge clk);
    #1;
    rstb = 1'b1;
    ena  = 1'b1;

    // No requests: everything stays quiet.
    repeat (100) step();

    // req[2], code 3 held: two back-to-back frames; in the second, code and req change mid-ON of blink 2.
    code = 16'h0300;
    req  = 4'b0100;
    expect_frame(2, 3, -1, cyc);
    expect_frame(2, 3, -1, -1);
    wait_grant(got);
    if (got) play(frame_end(3), 0, '0, code, -1);
    wait_grant(got);
    if (got) play(frame_end(3), BLK + ONC/2, 4'b0100, 16'h0100, -1);
    repeat (30) step();

    // Two requesters with code 1, held across four frames.
    code = 16'h1010;
    req  = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      w = arb(req, code);
      expect_frame(w, 1, -1, (k == 0) ? cyc : -1);
    end
    for (int k = 0; k < 4; k++) begin
      wait_grant(got);
      if (!got) break;
      play(frame_end(1), (k == 3) ? 1 : 0, 4'b1010, code, -1);
    end
    repeat (20) step();

    // Disable during the first OFF, then re-enable with the request still held.
    code = 16'h0300;
    req  = 4'b0100;
    expect_frame(2, 3, 12, cyc);
    wait_grant(got);
    if (got) play(13, 0, '0, code, 12);
    repeat (2) step();
    step();
    ena = 1'b1;
    w = arb(req, code);
    expect_frame(w, 3, -1, cyc);
    wait_grant(got);
    if (got) play(frame_end(3), 1, 4'b0100, code, -1);
    repeat (10) step();

    // Zero code on requester 0 is ignored even while its req stays high.
    code = 16'h2000;
    req  = 4'b1001;
    w = arb(req, code);
    expect_frame(w, 2, -1, cyc);
    wait_grant(got);
    if (got) play(frame_end(2), 1, 4'b1000, code, -1);
    repeat (40) step();
    req = '0;
    step();

    // Asynchronous reset in the middle of a frame.
    code = 16'h0020;
    req  = 4'b0010;
    expect_frame(1, 2, -1, cyc);
    wait_grant(got);
    if (got) play(10, 0, '0, code, -1);
    rstb  = 1'b0;
    req   = '0;
    m_ptr = 0;
    repeat (2) step();
    rstb = 1'b1;
    repeat (5) step();

    // Randomized frames with random masks, codes, mid-frame changes and occasional aborts.
    for (int n = 0; n < 30; n++) begin
      m = NREQ'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 3) == 0) cd[i*CW +: CW] = '0;
        else                           cd[i*CW +: CW] = CW'($urandom_range(1, 6));
      end
      step();
      code = cd;
      req  = m;
      w = arb(m, cd);
      if (w < 0) begin
        repeat (20) step();
        req = '0;
      end else begin
        e  = frame_end(slice(cd, w));
        ab = -1;
        if ($urandom_range(0, 3) == 0) ab = int'($urandom_range(1, e - 1));
        expect_frame(w, slice(cd, w), ab, cyc);
        wait_grant(got);
        if (got) begin
          rc = CDW'($urandom);
          play((ab > 0) ? ab + 1 : e, 1, {NREQ{1'b1}}, rc, ab);
          if (ab > 0) begin
            repeat (2) step();
            ena = 1'b1;
          end
        end
        repeat (3) step();
      end
    end

    repeat (5) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
